// File: rtl/uart_apb4_bridge_pkg.sv
// Shared types and constants for the UART byte-stream to APB4 initiator bridge.
package uart_apb4_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_e;

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;

  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_SLVERR = 8'h01;
  localparam logic [7:0] ST_BADCMD = 8'h02;

  localparam int unsigned RESP_W     = 40;
  localparam int unsigned RESP_CNT_W = 3;

  localparam logic [RESP_CNT_W-1:0] RESP_BYTES_WR = 3'd1;
  localparam logic [RESP_CNT_W-1:0] RESP_BYTES_RD = 3'd5;

endpackage

// File: rtl/uart_apb4_bridge_resp.sv
// Response serializer: loads up to five bytes at once and streams them LSB-first
// over a valid/ready byte interface.
module uart_apb4_bridge_resp
  import uart_apb4_bridge_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [RESP_W-1:0]     load_data_i,
  input  logic [RESP_CNT_W-1:0] load_count_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  last_o
);

  logic [RESP_W-1:0]     shift_q, shift_d;
  logic [RESP_CNT_W-1:0] count_q, count_d;
  logic                  tx_hs;

  assign tx_valid_o = (count_q != '0);
  assign tx_data_o  = shift_q[7:0];
  assign tx_hs      = tx_valid_o & tx_ready_i;
  assign last_o     = tx_hs & (count_q == RESP_CNT_W'(1));

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    if (load_i) begin
      shift_d = load_data_i;
      count_d = load_count_i;
    end else if (tx_hs) begin
      shift_d = {8'h00, shift_q[RESP_W-1:8]};
      count_d = count_q - RESP_CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      count_q <= '0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_apb4_bridge.sv
// UART command-frame decoder and single-transfer APB4 initiator.
// Optional inter-byte timeout: define UART_APB4_BRIDGE_BYTE_TIMEOUT_EN.
module uart_apb4_bridge
  import uart_apb4_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] paddr_o,
  output logic [2:0]  pprot_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  output logic [3:0]  pstrb_o,
  input  logic        pready_i,
  input  logic [31:0] prdata_i,
  input  logic        pslverr_i
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;

  logic                  rx_hs;
  logic                  resp_load;
  logic [RESP_W-1:0]     resp_data;
  logic [RESP_CNT_W-1:0] resp_count;
  logic                  resp_last;

  assign rx_ready_o = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_WDATA);
  assign rx_hs      = rx_valid_i & rx_ready_o;

  assign psel_o    = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign penable_o = (state_q == S_ACCESS);
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign pstrb_o   = pwrite_q ? 4'hF : 4'h0;
  assign pprot_o   = 3'b000;

`ifdef UART_APB4_BRIDGE_BYTE_TIMEOUT_EN
  logic [TO_WIDTH-1:0] to_q, to_d;
  logic                timeout_hit;

  // Idle cycles are counted only while a frame is partially received.
  always_comb begin
    to_d        = '0;
    timeout_hit = 1'b0;
    if (((state_q == S_ADDR) || (state_q == S_WDATA)) && !rx_hs) begin
      if (to_q == TO_WIDTH'(TIMEOUT_CYCLES - 1)) timeout_hit = 1'b1;
      else                                       to_d        = to_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) to_q <= '0;
    else       to_q <= to_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pwrite_d   = pwrite_q;
    resp_load  = 1'b0;
    resp_data  = '0;
    resp_count = '0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_hs) begin
          if ((rx_data_i == CMD_WR) || (rx_data_i == CMD_RD)) begin
            pwrite_d = (rx_data_i == CMD_WR);
            state_d  = S_ADDR;
          end else begin
            resp_load  = 1'b1;
            resp_data  = {32'h0, ST_BADCMD};
            resp_count = RESP_BYTES_WR;
            state_d    = S_RESP;
          end
        end
      end
      S_ADDR: begin
        if (rx_hs) begin
          paddr_d = {rx_data_i, paddr_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = pwrite_q ? S_WDATA : S_SETUP;
        end
      end
      S_WDATA: begin
        if (rx_hs) begin
          pwdata_d = {rx_data_i, pwdata_q[31:8]};
          cnt_d    = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_SETUP;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        // Completion data goes straight into the serializer; write responses send only the status.
        if (pready_i) begin
          resp_load  = 1'b1;
          resp_data  = {prdata_i, pslverr_i ? ST_SLVERR : ST_OK};
          resp_count = pwrite_q ? RESP_BYTES_WR : RESP_BYTES_RD;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef UART_APB4_BRIDGE_BYTE_TIMEOUT_EN
    if (timeout_hit) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
    end
  end

  uart_apb4_bridge_resp u_resp (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_i       (resp_load),
    .load_data_i  (resp_data),
    .load_count_i (resp_count),
    .tx_data_o    (tx_data_o),
    .tx_valid_o   (tx_valid_o),
    .tx_ready_i   (tx_ready_i),
    .last_o       (resp_last)
  );

endmodule

// File: tb/tb_uart_apb4_bridge.sv
// Self-checking bench for uart_apb4_bridge: directed frames plus randomized frames
// against a frame-level model of the command protocol.
`timescale 1ns/1ps
module tb_uart_apb4_bridge;
  import uart_apb4_bridge_pkg::*;

  typedef logic [7:0] bytes_t [$];

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic [31:0] paddr_o;
  logic [2:0]  pprot_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic        pready_i = 1'b0;
  logic [31:0] prdata_i = 32'h0;
  logic        pslverr_i = 1'b0;

  always #5 clk = ~clk;

`ifdef UART_APB4_BRIDGE_BYTE_TIMEOUT_EN
  uart_apb4_bridge #(.TIMEOUT_CYCLES(16)) dut (
`else
  uart_apb4_bridge dut (
`endif
    .clk_i      (clk),
    .rst_i      (rst_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .paddr_o    (paddr_o),
    .pprot_o    (pprot_o),
    .psel_o     (psel_o),
    .penable_o  (penable_o),
    .pwrite_o   (pwrite_o),
    .pwdata_o   (pwdata_o),
    .pstrb_o    (pstrb_o),
    .pready_i   (pready_i),
    .prdata_i   (prdata_i),
    .pslverr_i  (pslverr_i)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave and sink configuration, set per frame by the main sequence.
  int          cfg_ws = 0;
  logic [31:0] cfg_rdata = 32'h0;
  logic        cfg_err = 1'b0;
  int          cfg_stall_at = -1;
  int          stall_left = 0;
  bit          rand_ready = 1'b0;

  // Observations recorded by the APB slave and TX sink.
  bytes_t      got;
  int          apb_count = 0;
  int          psel_cycles = 0;
  int          ws_left = 0;
  bit          resp_due = 1'b0;
  logic [71:0] snap = '0;
  logic [31:0] txn_addr = '0;
  logic [31:0] txn_wdata = '0;
  logic        txn_write = 1'b0;
  logic [3:0]  txn_strb = '0;
  logic [2:0]  txn_prot = '0;

  // APB4 slave with programmable wait states; random garbage on prdata/pslverr while not ready.
  always @(negedge clk) begin
    if (rst_i) begin
      pready_i = 1'b0;
      resp_due = 1'b0;
    end else begin
      if (resp_due) begin
        check("resp_first_valid", 80'(tx_valid_o), 80'(1));
        check("apb_drop", 80'({psel_o, penable_o}), 80'(0));
        resp_due = 1'b0;
      end
      pready_i  = 1'b0;
      prdata_i  = $urandom;
      pslverr_i = 1'($urandom_range(0, 1));
      if (psel_o) psel_cycles++;
      if (psel_o && !penable_o) begin
        snap    = {paddr_o, pwrite_o, pwdata_o, pstrb_o, pprot_o};
        ws_left = cfg_ws;
      end else if (psel_o && penable_o) begin
        check("apb_stable", 80'({paddr_o, pwrite_o, pwdata_o, pstrb_o, pprot_o}), 80'(snap));
        if (ws_left == 0) begin
          pready_i  = 1'b1;
          prdata_i  = cfg_rdata;
          pslverr_i = cfg_err;
          txn_addr  = paddr_o;
          txn_wdata = pwdata_o;
          txn_write = pwrite_o;
          txn_strb  = pstrb_o;
          txn_prot  = pprot_o;
          apb_count++;
          resp_due  = 1'b1;
        end else begin
          ws_left--;
        end
      end
    end
  end

  // TX FIFO sink with optional stall window and random readiness.
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (rst_i) begin
      tx_ready_i = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("tx_hold_valid", 80'(tx_valid_o), 80'(1));
        check("tx_hold_data", 80'(tx_data_o), 80'(prev_data));
      end
      if (tx_valid_o) check("rx_blocked_in_resp", 80'(rx_ready_o), 80'(0));
      if (tx_valid_o && (cfg_stall_at == got.size()) && (stall_left > 0)) begin
        tx_ready_i = 1'b0;
        stall_left--;
      end else if (rand_ready) begin
        tx_ready_i = ($urandom_range(0, 3) != 0);
      end else begin
        tx_ready_i = 1'b1;
      end
      if (tx_valid_o && tx_ready_i) got.push_back(tx_data_o);
      prev_valid = tx_valid_o;
      prev_ready = tx_ready_i;
      prev_data  = tx_data_o;
    end
  end

  function automatic bytes_t make_frame(input logic [7:0] cmd, input logic [31:0] addr,
                                        input logic [31:0] data);
    bytes_t f;
    f.push_back(cmd);
    if ((cmd == CMD_WR) || (cmd == CMD_RD))
      for (int i = 0; i < 4; i++) f.push_back(addr[8*i +: 8]);
    if (cmd == CMD_WR)
      for (int i = 0; i < 4; i++) f.push_back(data[8*i +: 8]);
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic rdy;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    n = 0;
    do begin
      rdy = rx_ready_o;
      @(negedge clk);
      n++;
    end while (!rdy && (n < 2000));
    rx_valid_i = 1'b0;
    rx_data_i  = 8'($urandom);
    if (!rdy) check("rx_accept_timeout", 80'(rdy), 80'(1));
  endtask

  // Model: decode the frame bytes into the expected APB transfer and response bytes.
  task automatic run_frame(input bytes_t f, input int ws, input logic [31:0] rdata,
                           input logic err, input int stall_at, input string tag);
    bytes_t      exp;
    bit          is_wr, valid_cmd;
    logic [31:0] m_addr, m_wdata;
    int          apb0, psel0, n;
    is_wr     = (f[0] == CMD_WR);
    valid_cmd = is_wr || (f[0] == CMD_RD);
    m_addr    = '0;
    m_wdata   = '0;
    if (valid_cmd) m_addr = {f[4], f[3], f[2], f[1]};
    if (is_wr)     m_wdata = {f[8], f[7], f[6], f[5]};
    if (!valid_cmd) exp.push_back(ST_BADCMD);
    else begin
      exp.push_back(err ? ST_SLVERR : ST_OK);
      if (!is_wr) for (int i = 0; i < 4; i++) exp.push_back(rdata[8*i +: 8]);
    end
    cfg_ws = ws; cfg_rdata = rdata; cfg_err = err;
    cfg_stall_at = stall_at; stall_left = 10;
    got.delete();
    apb0  = apb_count;
    psel0 = psel_cycles;
    foreach (f[i]) begin
      send_byte(f[i]);
      if (valid_cmd && (i == f.size() - 1)) begin
        check({tag, "_setup"}, 80'({psel_o, penable_o}), 80'(2'b10));
        @(negedge clk);
        check({tag, "_access"}, 80'({psel_o, penable_o}), 80'(2'b11));
      end
    end
    n = 0;
    while (((got.size() < exp.size()) || tx_valid_o || !rx_ready_o) && (n < 5000)) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_complete"}, 80'(n < 5000), 80'(1));
    repeat (3) @(negedge clk);
    check({tag, "_nbytes"}, 80'(got.size()), 80'(exp.size()));
    foreach (exp[i])
      if (i < got.size()) check($sformatf("%s_byte%0d", tag, i), 80'(got[i]), 80'(exp[i]));
    check({tag, "_apb_count"}, 80'(apb_count - apb0), 80'(valid_cmd ? 1 : 0));
    if (valid_cmd) begin
      check({tag, "_paddr"}, 80'(txn_addr), 80'(m_addr));
      check({tag, "_pwrite"}, 80'(txn_write), 80'(is_wr));
      check({tag, "_pstrb"}, 80'(txn_strb), 80'(is_wr ? 4'hF : 4'h0));
      check({tag, "_pprot"}, 80'(txn_prot), 80'(0));
      if (is_wr) check({tag, "_pwdata"}, 80'(txn_wdata), 80'(m_wdata));
    end else begin
      check({tag, "_no_psel"}, 80'(psel_cycles - psel0), 80'(0));
    end
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bytes_t      f;
    int          apb0, sel;
    logic [7:0]  cmd;

    repeat (3) @(negedge clk);
    check("rst_ctrl", 80'({psel_o, penable_o, pwrite_o, tx_valid_o}), 80'(0));
    check("rst_data", 80'({paddr_o, pwdata_o, pstrb_o, tx_data_o, pprot_o}), 80'(0));
    rst_i = 1'b0;
    check("rst_rx_ready", 80'(rx_ready_o), 80'(1));
    @(negedge clk);
    check("post_rst_rx_ready", 80'(rx_ready_o), 80'(1));

    run_frame(make_frame(CMD_WR, 32'h4000_0010, 32'hDEAD_BEEF), 0, 32'h0, 1'b0, -1, "wr");
    run_frame(make_frame(CMD_RD, 32'h4000_0004, 32'h0), 3, 32'h1234_5678, 1'b0, -1, "rd_ws3");
    run_frame(make_frame(CMD_WR, 32'h0000_0FFC, 32'h0102_0304), 1, 32'h0, 1'b1, -1, "wr_err");
    run_frame(make_frame(CMD_RD, 32'hFFFF_FFFC, 32'h0), 0, 32'hA5C3_0F96, 1'b1, -1, "rd_err");
    run_frame(make_frame(8'h41, 32'h0, 32'h0), 0, 32'h0, 1'b0, -1, "badcmd");
    run_frame(make_frame(CMD_RD, 32'h2000_0008, 32'h0), 2, 32'hCAFE_F00D, 1'b0, -1, "rd_after_bad");
    run_frame(make_frame(CMD_RD, 32'h3000_0000, 32'h0), 0, 32'h8899_AABB, 1'b0, 2, "rd_stall");

    // Reset while the bridge waits in ACCESS.
    cfg_ws = 8; cfg_stall_at = -1; got.delete();
    apb0 = apb_count;
    f = make_frame(CMD_RD, 32'h0000_0100, 32'h0);
    foreach (f[i]) send_byte(f[i]);
    repeat (2) @(negedge clk);
    check("pre_rst_access", 80'({psel_o, penable_o}), 80'(2'b11));
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("mid_rst_apb", 80'({psel_o, penable_o, tx_valid_o}), 80'(0));
    check("mid_rst_rx_ready", 80'(rx_ready_o), 80'(1));
    repeat (5) @(negedge clk);
    check("mid_rst_no_apb", 80'(apb_count - apb0), 80'(0));
    check("mid_rst_no_tx", 80'(got.size()), 80'(0));
    run_frame(make_frame(CMD_WR, 32'h0000_0200, 32'h5555_AAAA), 0, 32'h0, 1'b0, -1, "wr_after_rst");

`ifdef UART_APB4_BRIDGE_BYTE_TIMEOUT_EN
    got.delete();
    apb0 = apb_count;
    send_byte(CMD_RD);
    send_byte(8'h10);
    send_byte(8'h20);
    repeat (20) @(negedge clk);
    check("timeout_idle_rx_ready", 80'(rx_ready_o), 80'(1));
    check("timeout_no_tx", 80'(got.size()), 80'(0));
    check("timeout_no_apb", 80'(apb_count - apb0), 80'(0));
    run_frame(make_frame(CMD_RD, 32'h4000_0020, 32'h0), 1, 32'h0BAD_F00D, 1'b0, -1, "rd_after_timeout");
`endif

    rand_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)      cmd = CMD_WR;
      else if (sel < 8) cmd = CMD_RD;
      else begin
        cmd = 8'($urandom);
        if ((cmd == CMD_WR) || (cmd == CMD_RD)) cmd = 8'h00;
      end
      run_frame(make_frame(cmd, $urandom, $urandom), $urandom_range(0, 3), $urandom,
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 1 : -1,
                $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
